// File: rtl/pe_result_drain_pkg.sv
// Shared definitions for the PE result drain: FSM encoding and default widths.
package pe_result_drain_pkg;

  localparam int unsigned WidthAccDefault = 32;
  localparam int unsigned LenWDefault     = 8;
  localparam int unsigned DepthDefault    = 4;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } drain_state_e;

endpackage

// File: rtl/pe_result_drain_if.sv
// Valid/ready result stream from the drain towards the writeback path.
interface pe_result_drain_if #(
  parameter int unsigned WidthAcc = 32
);
  logic [WidthAcc-1:0] data;
  logic                valid;
  logic                ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pe_result_drain_fifo.sv
// Synchronous show-ahead FIFO; head word is 0 when empty, memory is not reset.
module pe_result_drain_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     accepted,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             do_pop;

  assign full     = (cnt_q == (PtrW + 1)'(Depth));
  assign empty    = (cnt_q == '0);
  assign level    = cnt_q;
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees a slot even when full.
  assign accepted = push && (!full || do_pop);
  assign rdata    = empty ? '0 : mem[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (accepted) wptr_d = wptr_q + 1'b1;
    if (do_pop)   rptr_d = rptr_q + 1'b1;
    if (accepted && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!accepted && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && accepted) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/pe_result_drain.sv
// Windows a free-running PE accumulator into per-K-beat dot-products and queues them.
module pe_result_drain
  import pe_result_drain_pkg::*;
#(
  parameter int unsigned WidthAcc = WidthAccDefault,
  parameter int unsigned LenW     = LenWDefault,
  parameter int unsigned Depth    = DepthDefault
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LenW-1:0]        cfg_len,
  input  logic                   start,
  input  logic                   stop,
  input  logic [WidthAcc-1:0]    pe_acc,
  input  logic                   pe_valid,
  pe_result_drain_if.master      m,
  output logic                   busy,
  output logic [$clog2(Depth):0] level,
  output logic                   overflow
);
  drain_state_e        state_q, state_d;
  logic [LenW-1:0]     cnt_q, cnt_d, len_q, len_d;
  logic [WidthAcc-1:0] base_q, base_d;
  logic                ovf_q, ovf_d;
  logic                push, accepted, full, empty;
  logic [WidthAcc-1:0] result;

  // Modular subtraction keeps results correct across accumulator wrap.
  assign result = pe_acc - base_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    base_d  = base_q;
    push    = 1'b0;
    if (stop) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && cfg_len != '0) begin
            state_d = StRun;
            len_d   = cfg_len;
            base_d  = pe_acc;
            cnt_d   = '0;
          end
        end
        StRun: begin
          if (start) begin
            len_d  = cfg_len;
            base_d = pe_acc;
            cnt_d  = '0;
          end else if (pe_valid) begin
            if (cnt_q == len_q - LenW'(1)) begin
              push   = 1'b1;
              base_d = pe_acc;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + LenW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign ovf_d = ovf_q || (push && !accepted);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      base_q  <= base_d;
      ovf_q   <= ovf_d;
    end
  end

  pe_result_drain_fifo #(
    .Width (WidthAcc),
    .Depth (Depth)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .wdata    (result),
    .pop      (m.ready),
    .rdata    (m.data),
    .accepted (accepted),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  assign m.valid  = !empty;
  assign busy     = (state_q == StRun);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain with hand-computed expectations.
module tb_pe_result_drain;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cfg_len;
  logic        start, stop;
  logic [31:0] pe_acc;
  logic        pe_valid;
  logic        busy, overflow;
  logic [2:0]  level;
  int          checks = 0;
  int          errors = 0;

  pe_result_drain_if #(.WidthAcc(32)) m_if ();

  pe_result_drain #(.WidthAcc(32), .LenW(8), .Depth(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_len  (cfg_len),
    .start    (start),
    .stop     (stop),
    .pe_acc   (pe_acc),
    .pe_valid (pe_valid),
    .m        (m_if.master),
    .busy     (busy),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] acc);
    pe_acc   = acc;
    pe_valid = 1'b1;
    tick();
    pe_valid = 1'b0;
  endtask

  task automatic arm(input logic [31:0] acc, input logic [7:0] len);
    pe_acc  = acc;
    cfg_len = len;
    start   = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_len = '0; start = 0; stop = 0; pe_acc = '0; pe_valid = 0;
    m_if.ready = 1'b1;
    tick(); tick();
    check("rst_valid", 64'(m_if.valid), 0);
    check("rst_data", 64'(m_if.data), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_level", 64'(level), 0);
    check("rst_ovf", 64'(overflow), 0);
    rst_n = 1'b1;
    tick();

    // 1: window of 4 beats
    arm(32'd0, 8'd4);
    check("t1_busy", 64'(busy), 1);
    beat(32'd1); beat(32'd3); beat(32'd6);
    check("t1_early", 64'(m_if.valid), 0);
    beat(32'd10);
    check("t1_valid", 64'(m_if.valid), 1);
    check("t1_data", 64'(m_if.data), 64'd10);
    tick();
    check("t1_drained", 64'(level), 0);

    // 2: nonzero baseline and accumulator wrap
    arm(32'd100, 8'd2);
    beat(32'd105); beat(32'd102);
    check("t2_data", 64'(m_if.data), 64'd2);
    tick();
    arm(32'h7FFF_FFF0, 8'd2);
    beat(32'h8000_0000); beat(32'h8000_0010);
    check("t2_wrap", 64'(m_if.data), 64'h20);
    tick();
    stop = 1'b1; tick(); stop = 1'b0;

    // 3: overflow with stalled consumer
    m_if.ready = 1'b0;
    arm(32'd0, 8'd1);
    for (int i = 1; i <= 5; i++) beat(32'(i));
    check("t3_level", 64'(level), 4);
    check("t3_ovf", 64'(overflow), 1);
    m_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_pop", 64'({m_if.valid, m_if.data}), 64'({1'b1, 32'd1}));
      tick();
    end
    check("t3_empty", 64'(level), 0);

    // 4: full FIFO, push with simultaneous pop
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m_if.ready = 1'b0;
    arm(32'd0, 8'd1);
    beat(32'd1); beat(32'd3); beat(32'd6); beat(32'd10);
    check("t4_full", 64'(level), 4);
    m_if.ready = 1'b1;
    beat(32'd15);
    check("t4_level", 64'(level), 4);
    check("t4_ovf", 64'(overflow), 0);
    for (int i = 2; i <= 5; i++) begin
      check("t4_order", 64'(m_if.data), 64'(i));
      tick();
    end
    check("t4_empty", 64'(m_if.valid), 0);

    // 5: stop discards partial window; start+stop and len=0 ignored
    stop = 1'b1; tick(); stop = 1'b0;
    arm(32'd0, 8'd4);
    beat(32'd1); beat(32'd2);
    stop = 1'b1; tick(); stop = 1'b0;
    check("t5_busy", 64'(busy), 0);
    beat(32'd3); beat(32'd4);
    check("t5_nopush", 64'(m_if.valid), 0);
    stop = 1'b1; arm(32'd0, 8'd4); stop = 1'b0;
    check("t5_startstop", 64'(busy), 0);
    arm(32'd0, 8'd0);
    check("t5_len0", 64'(busy), 0);

    // 6: reset mid-window with queued results
    m_if.ready = 1'b0;
    arm(32'd0, 8'd1);
    beat(32'd7); beat(32'd9);
    check("t6_queued", 64'(level), 2);
    arm(32'd9, 8'd4);
    beat(32'd11);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("t6_valid", 64'(m_if.valid), 0);
    check("t6_level", 64'(level), 0);
    check("t6_busy", 64'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
